// File: rtl/gpu_vram_pkg.sv
// Shared types and constants for the VRAM access scheduler.
// Holds the CPU address map, memory address widths, region and read-FSM
// enums, the write-FIFO entry layout and the address decode function.
package gpu_vram_pkg;

  localparam int unsigned CPU_AW   = 16;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned TILE_AW  = 11;
  localparam int unsigned ATTR_AW  = 12;
  localparam int unsigned COLOR_AW = 4;
  // Entries carry the widest region offset; narrower regions use the low bits.
  localparam int unsigned ENTRY_AW = ATTR_AW;

  localparam logic [CPU_AW-1:0] TILE_BASE  = 16'h0000;
  localparam logic [CPU_AW-1:0] TILE_MASK  = 16'hF800;
  localparam logic [CPU_AW-1:0] ATTR_BASE  = 16'h1000;
  localparam logic [CPU_AW-1:0] ATTR_MASK  = 16'hF000;
  localparam logic [CPU_AW-1:0] COLOR_BASE = 16'h2000;
  localparam logic [CPU_AW-1:0] COLOR_MASK = 16'hFFF0;

  typedef enum logic [1:0] {REG_TILE, REG_ATTR, REG_COLOR, REG_NONE} region_t;

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DATA} state_t;

  typedef struct packed {
    region_t               region;
    logic [ENTRY_AW-1:0]   addr;
    logic [DATA_W-1:0]     data;
  } wr_entry_t;

  // Map a unified CPU address onto the memory it targets.
  function automatic region_t decode_region(input logic [CPU_AW-1:0] addr);
    if ((addr & TILE_MASK) == TILE_BASE) return REG_TILE;
    if ((addr & ATTR_MASK) == ATTR_BASE) return REG_ATTR;
    if ((addr & COLOR_MASK) == COLOR_BASE) return REG_COLOR;
    return REG_NONE;
  endfunction

endpackage

// File: rtl/vram_write_fifo.sv
// Synchronous FIFO buffering decoded CPU writes.
// Ports: clk, reset_n (async active-low), push/push_entry (enqueue),
// pop (dequeue), head_c (combinational view of the oldest entry),
// full, empty (derived from the registered occupancy count).
module vram_write_fifo
  import gpu_vram_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      push,
  input  wr_entry_t push_entry,
  input  logic      pop,
  output wr_entry_t head_c,
  output logic      full,
  output logic      empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  wr_entry_t          mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               do_push;
  logic               do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign head_c  = mem[rd_ptr];

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vram_access_scheduler.sv
// Schedules CPU accesses into the tile, attribute and color memories.
// CPU writes are queued and drained one per cycle to the memory write ports;
// CPU reads share each memory's read port with the renderer, which wins.
// Ports: clk, reset_n; cpu_req_* / cpu_rsp_* CPU bus; render_*_read_* renderer
// requests; *_memory_read_* / *_memory_write_* memory ports; render_stall;
// unmapped_count (saturating).
// Optional macro STARVE_GUARD_EN: after STARVE_LIMIT waiting cycles a pending
// CPU read steals the port for one cycle and render_stall flags that cycle.
module vram_access_scheduler
  import gpu_vram_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STARVE_LIMIT = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cpu_req_valid,
  input  logic                cpu_req_rw,
  input  logic [CPU_AW-1:0]   cpu_req_addr,
  input  logic [DATA_W-1:0]   cpu_req_data,
  output logic                cpu_req_ready,
  output logic                cpu_rsp_valid,
  output logic [DATA_W-1:0]   cpu_rsp_data,
  input  logic                render_tile_read_enable,
  input  logic                render_attribute_read_enable,
  input  logic                render_color_read_enable,
  input  logic [TILE_AW-1:0]  render_tile_read_addr,
  input  logic [ATTR_AW-1:0]  render_attribute_read_addr,
  input  logic [COLOR_AW-1:0] render_color_read_addr,
  output logic                render_stall,
  output logic                tile_memory_read_enable,
  output logic                attribute_memory_read_enable,
  output logic                color_memory_read_enable,
  output logic [TILE_AW-1:0]  tile_memory_read_addr,
  output logic [ATTR_AW-1:0]  attribute_memory_read_addr,
  output logic [COLOR_AW-1:0] color_memory_read_addr,
  input  logic [DATA_W-1:0]   tile_memory_read_data,
  input  logic [DATA_W-1:0]   attribute_memory_read_data,
  input  logic [DATA_W-1:0]   color_memory_read_data,
  output logic                tile_memory_write_enable,
  output logic                attribute_memory_write_enable,
  output logic                color_memory_write_enable,
  output logic [TILE_AW-1:0]  tile_memory_write_addr,
  output logic [ATTR_AW-1:0]  attribute_memory_write_addr,
  output logic [COLOR_AW-1:0] color_memory_write_addr,
  output logic [DATA_W-1:0]   tile_memory_write_data,
  output logic [DATA_W-1:0]   attribute_memory_write_data,
  output logic [DATA_W-1:0]   color_memory_write_data,
  output logic [7:0]          unmapped_count
);

  state_t              state;
  region_t             rd_region;
  logic [ENTRY_AW-1:0] rd_addr;
  region_t             req_region;
  wr_entry_t           push_entry;
  wr_entry_t           head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                pop;
  logic                accept;
  logic                write_active;
  logic                target_render_en;
  logic                steal;
  logic                cpu_grant;
  logic [DATA_W-1:0]   rsp_sel;
  logic [1:0]          unmapped_incr;
  logic [8:0]          unmapped_sum;

  assign req_region   = decode_region(cpu_req_addr);
  assign write_active = tile_memory_write_enable || attribute_memory_write_enable ||
                        color_memory_write_enable;

  // Reads wait for every queued and in-flight write so they observe it.
  assign cpu_req_ready = (state == IDLE) &&
                         (cpu_req_rw ? (fifo_empty && !write_active) : !fifo_full);
  assign accept        = cpu_req_valid && cpu_req_ready;
  assign push          = accept && !cpu_req_rw;
  assign pop           = !fifo_empty;
  assign push_entry    = '{region: req_region, addr: cpu_req_addr[ENTRY_AW-1:0],
                           data: cpu_req_data};

  vram_write_fifo #(.DEPTH(FIFO_DEPTH)) u_write_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head_c     (head),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  // Renderer request and memory data for the region of the pending read.
  always_comb begin
    target_render_en = 1'b0;
    rsp_sel          = '0;
    case (rd_region)
      REG_TILE: begin
        target_render_en = render_tile_read_enable;
        rsp_sel          = tile_memory_read_data;
      end
      REG_ATTR: begin
        target_render_en = render_attribute_read_enable;
        rsp_sel          = attribute_memory_read_data;
      end
      REG_COLOR: begin
        target_render_en = render_color_read_enable;
        rsp_sel          = color_memory_read_data;
      end
      default: begin
        target_render_en = 1'b0;
        rsp_sel          = '0;
      end
    endcase
  end

  assign cpu_grant = (state == RD_WAIT) && (!target_render_en || steal);

`ifdef STARVE_GUARD_EN
  localparam int unsigned WAIT_W = $clog2(STARVE_LIMIT + 1);

  logic [WAIT_W-1:0] wait_cnt;
  logic              steal_q;

  // Counts blocked RD_WAIT cycles; the cycle after the limit is a forced steal.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
      steal_q  <= 1'b0;
    end else if (state == RD_WAIT && !cpu_grant) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
      steal_q  <= (wait_cnt == WAIT_W'(STARVE_LIMIT - 1));
    end else begin
      wait_cnt <= '0;
      steal_q  <= 1'b0;
    end
  end

  assign steal        = steal_q;
  assign render_stall = steal_q;
`else
  // The starvation limit only matters when the guard is built in.
  localparam int unsigned unused_starve_limit = STARVE_LIMIT;

  assign steal        = 1'b0;
  assign render_stall = 1'b0;
`endif

  // Read port sharing: renderer address unless the CPU holds the grant.
  assign tile_memory_read_enable      = render_tile_read_enable ||
                                        (cpu_grant && rd_region == REG_TILE);
  assign attribute_memory_read_enable = render_attribute_read_enable ||
                                        (cpu_grant && rd_region == REG_ATTR);
  assign color_memory_read_enable     = render_color_read_enable ||
                                        (cpu_grant && rd_region == REG_COLOR);
  assign tile_memory_read_addr        = (cpu_grant && rd_region == REG_TILE) ?
                                        rd_addr[TILE_AW-1:0] : render_tile_read_addr;
  assign attribute_memory_read_addr   = (cpu_grant && rd_region == REG_ATTR) ?
                                        rd_addr[ATTR_AW-1:0] : render_attribute_read_addr;
  assign color_memory_read_addr       = (cpu_grant && rd_region == REG_COLOR) ?
                                        rd_addr[COLOR_AW-1:0] : render_color_read_addr;

  // Unmapped writes and unmapped reads can each add one per cycle.
  assign unmapped_incr = 2'(pop && head.region == REG_NONE) +
                         2'(state == RD_DATA && rd_region == REG_NONE);
  assign unmapped_sum  = {1'b0, unmapped_count} + 9'(unmapped_incr);

  // Read FSM, response register, write-port drain and unmapped counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                         <= IDLE;
      rd_region                     <= REG_NONE;
      rd_addr                       <= '0;
      cpu_rsp_valid                 <= 1'b0;
      cpu_rsp_data                  <= '0;
      tile_memory_write_enable      <= 1'b0;
      attribute_memory_write_enable <= 1'b0;
      color_memory_write_enable     <= 1'b0;
      tile_memory_write_addr        <= '0;
      attribute_memory_write_addr   <= '0;
      color_memory_write_addr       <= '0;
      tile_memory_write_data        <= '0;
      attribute_memory_write_data   <= '0;
      color_memory_write_data       <= '0;
      unmapped_count                <= '0;
    end else begin
      cpu_rsp_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (accept && cpu_req_rw) begin
            rd_addr   <= cpu_req_addr[ENTRY_AW-1:0];
            rd_region <= req_region;
            state     <= (req_region == REG_NONE) ? RD_DATA : RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (cpu_grant) state <= RD_DATA;
        end
        RD_DATA: begin
          cpu_rsp_valid <= 1'b1;
          cpu_rsp_data  <= rsp_sel;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase

      tile_memory_write_enable      <= pop && head.region == REG_TILE;
      attribute_memory_write_enable <= pop && head.region == REG_ATTR;
      color_memory_write_enable     <= pop && head.region == REG_COLOR;
      if (pop && head.region == REG_TILE) begin
        tile_memory_write_addr <= head.addr[TILE_AW-1:0];
        tile_memory_write_data <= head.data;
      end
      if (pop && head.region == REG_ATTR) begin
        attribute_memory_write_addr <= head.addr[ATTR_AW-1:0];
        attribute_memory_write_data <= head.data;
      end
      if (pop && head.region == REG_COLOR) begin
        color_memory_write_addr <= head.addr[COLOR_AW-1:0];
        color_memory_write_data <= head.data;
      end

      unmapped_count <= unmapped_sum[8] ? 8'hFF : unmapped_sum[7:0];
    end
  end

endmodule

// File: tb/tb_vram_access_scheduler.sv
// Self-checking bench for vram_access_scheduler: directed CPU/renderer
// traffic, memory models, and a scoreboard of expected writes and read data.
`timescale 1ns/1ps
module tb_vram_access_scheduler;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_req_valid = 1'b0, cpu_req_rw = 1'b0;
  logic [15:0] cpu_req_addr = '0;
  logic [7:0]  cpu_req_data = '0;
  logic        cpu_req_ready, cpu_rsp_valid;
  logic [7:0]  cpu_rsp_data;
  logic        render_tile_read_enable = 1'b0, render_attribute_read_enable = 1'b0;
  logic        render_color_read_enable = 1'b0;
  logic [10:0] render_tile_read_addr = '0;
  logic [11:0] render_attribute_read_addr = '0;
  logic [3:0]  render_color_read_addr = '0;
  logic        render_stall;
  logic        tile_memory_read_enable, attribute_memory_read_enable, color_memory_read_enable;
  logic [10:0] tile_memory_read_addr;
  logic [11:0] attribute_memory_read_addr;
  logic [3:0]  color_memory_read_addr;
  logic [7:0]  tile_memory_read_data, attribute_memory_read_data, color_memory_read_data;
  logic        tile_memory_write_enable, attribute_memory_write_enable, color_memory_write_enable;
  logic [10:0] tile_memory_write_addr;
  logic [11:0] attribute_memory_write_addr;
  logic [3:0]  color_memory_write_addr;
  logic [7:0]  tile_memory_write_data, attribute_memory_write_data, color_memory_write_data;
  logic [7:0]  unmapped_count;

  vram_access_scheduler #(.FIFO_DEPTH(4), .STARVE_LIMIT(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req_valid(cpu_req_valid), .cpu_req_rw(cpu_req_rw), .cpu_req_addr(cpu_req_addr),
    .cpu_req_data(cpu_req_data), .cpu_req_ready(cpu_req_ready),
    .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_data(cpu_rsp_data),
    .render_tile_read_enable(render_tile_read_enable),
    .render_attribute_read_enable(render_attribute_read_enable),
    .render_color_read_enable(render_color_read_enable),
    .render_tile_read_addr(render_tile_read_addr),
    .render_attribute_read_addr(render_attribute_read_addr),
    .render_color_read_addr(render_color_read_addr),
    .render_stall(render_stall),
    .tile_memory_read_enable(tile_memory_read_enable),
    .attribute_memory_read_enable(attribute_memory_read_enable),
    .color_memory_read_enable(color_memory_read_enable),
    .tile_memory_read_addr(tile_memory_read_addr),
    .attribute_memory_read_addr(attribute_memory_read_addr),
    .color_memory_read_addr(color_memory_read_addr),
    .tile_memory_read_data(tile_memory_read_data),
    .attribute_memory_read_data(attribute_memory_read_data),
    .color_memory_read_data(color_memory_read_data),
    .tile_memory_write_enable(tile_memory_write_enable),
    .attribute_memory_write_enable(attribute_memory_write_enable),
    .color_memory_write_enable(color_memory_write_enable),
    .tile_memory_write_addr(tile_memory_write_addr),
    .attribute_memory_write_addr(attribute_memory_write_addr),
    .color_memory_write_addr(color_memory_write_addr),
    .tile_memory_write_data(tile_memory_write_data),
    .attribute_memory_write_data(attribute_memory_write_data),
    .color_memory_write_data(color_memory_write_data),
    .unmapped_count(unmapped_count)
  );

  always #5 clk = ~clk;

  // Memory models: synchronous write, read data valid the cycle after enable.
  logic [7:0] tile_mem [2048];
  logic [7:0] attr_mem [4096];
  logic [7:0] color_mem [16];

  always @(posedge clk) begin
    if (tile_memory_write_enable) tile_mem[tile_memory_write_addr] <= tile_memory_write_data;
    if (attribute_memory_write_enable)
      attr_mem[attribute_memory_write_addr] <= attribute_memory_write_data;
    if (color_memory_write_enable) color_mem[color_memory_write_addr] <= color_memory_write_data;
    if (tile_memory_read_enable) tile_memory_read_data <= tile_mem[tile_memory_read_addr];
    if (attribute_memory_read_enable)
      attribute_memory_read_data <= attr_mem[attribute_memory_read_addr];
    if (color_memory_read_enable) color_memory_read_data <= color_mem[color_memory_read_addr];
  end

  // Scoreboard state.
  typedef struct packed {
    logic [1:0]  region;
    logic [11:0] addr;
    logic [7:0]  data;
  } wr_t;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          stall_count = 0;
  int          stall_cyc = -1;
  int          model_unmapped = 0;
  logic        checking = 1'b0;
  logic        prev_rsp = 1'b0;
  wr_t         exp_wr[$];
  wr_t         obs[$];
  logic [7:0]  exp_rd[$];
  logic [7:0]  shadow [logic [15:0]];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Address map as plain ranges: 0 tile, 1 attribute, 2 color, 3 unmapped.
  function automatic int region_of(input logic [15:0] a);
    if (a <= 16'h07FF) return 0;
    if (a >= 16'h1000 && a <= 16'h1FFF) return 1;
    if (a >= 16'h2000 && a <= 16'h200F) return 2;
    return 3;
  endfunction

  function automatic logic [11:0] offset_of(input logic [15:0] a, input int r);
    if (r == 1) return 12'(a - 16'h1000);
    if (r == 2) return 12'(a - 16'h2000);
    return 12'(a);
  endfunction

  task automatic note_write(input int r, input logic [11:0] a, input logic [7:0] d);
    wr_t got, e;
    got = '{region: 2'(r), addr: a, data: d};
    obs.push_back(got);
    if (exp_wr.size() == 0) chk("unexpected_write", 32'(got), 32'hFFFF_FFFF);
    else begin
      e = exp_wr.pop_front();
      chk("write_port", 32'(got), 32'(e));
    end
  endtask

  // Per-cycle comparison against the scoreboard and the renderer's requests.
  always @(negedge clk) begin
    if (reset_n && checking) begin
      if (tile_memory_write_enable)
        note_write(0, 12'(tile_memory_write_addr), tile_memory_write_data);
      if (attribute_memory_write_enable)
        note_write(1, attribute_memory_write_addr, attribute_memory_write_data);
      if (color_memory_write_enable)
        note_write(2, 12'(color_memory_write_addr), color_memory_write_data);
      if (cpu_rsp_valid) begin
        if (exp_rd.size() == 0) chk("unexpected_rsp", 32'(cpu_rsp_data), 32'hFFFF_FFFF);
        else chk("rsp_data", 32'(cpu_rsp_data), 32'(exp_rd.pop_front()));
        if (prev_rsp) chk("rsp_pulse_width", 32'(2), 32'(1));
      end
      if (render_tile_read_enable && !render_stall) begin
        chk("tile_rd_en", 32'(tile_memory_read_enable), 32'(1));
        chk("tile_rd_addr", 32'(tile_memory_read_addr), 32'(render_tile_read_addr));
      end
      if (render_attribute_read_enable && !render_stall) begin
        chk("attr_rd_en", 32'(attribute_memory_read_enable), 32'(1));
        chk("attr_rd_addr", 32'(attribute_memory_read_addr), 32'(render_attribute_read_addr));
      end
      if (render_color_read_enable && !render_stall) begin
        chk("color_rd_en", 32'(color_memory_read_enable), 32'(1));
        chk("color_rd_addr", 32'(color_memory_read_addr), 32'(render_color_read_addr));
      end
      if (render_stall) begin
        stall_count++;
        stall_cyc = cyc;
      end
    end
    prev_rsp = cpu_rsp_valid;
  end

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, output int waits);
    int r;
    waits = 0;
    cpu_req_valid = 1'b1; cpu_req_rw = 1'b0; cpu_req_addr = a; cpu_req_data = d;
    @(negedge clk);
    while (!cpu_req_ready && waits < 300) begin
      waits++;
      @(negedge clk);
    end
    if (!cpu_req_ready) chk("write_accept_timeout", 32'(0), 32'(1));
    else begin
      r = region_of(a);
      if (r == 3) model_unmapped = (model_unmapped >= 255) ? 255 : model_unmapped + 1;
      else begin
        exp_wr.push_back('{region: 2'(r), addr: offset_of(a, r), data: d});
        shadow[a] = d;
      end
    end
    @(posedge clk); #1;
    cpu_req_valid = 1'b0;
  endtask

  task automatic cpu_read(input logic [15:0] a, output int waits, output int acc_cyc,
                          output int rsp_cyc);
    int r;
    waits = 0;
    rsp_cyc = -1;
    cpu_req_valid = 1'b1; cpu_req_rw = 1'b1; cpu_req_addr = a; cpu_req_data = 8'h00;
    @(negedge clk);
    while (!cpu_req_ready && waits < 300) begin
      waits++;
      @(negedge clk);
    end
    if (!cpu_req_ready) chk("read_accept_timeout", 32'(0), 32'(1));
    else begin
      r = region_of(a);
      if (r == 3) begin
        model_unmapped = (model_unmapped >= 255) ? 255 : model_unmapped + 1;
        exp_rd.push_back(8'h00);
      end else exp_rd.push_back(shadow.exists(a) ? shadow[a] : 8'h00);
    end
    @(posedge clk); #1;
    cpu_req_valid = 1'b0; cpu_req_rw = 1'b0;
    acc_cyc = cyc;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (cpu_rsp_valid) begin
        rsp_cyc = cyc;
        break;
      end
    end
    if (rsp_cyc < 0) chk("rsp_timeout", 32'(0), 32'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w, acc, rsp, fall, tot, s0;
    logic [15:0] bw_addr [7];
    logic [7:0]  bw_data [7];
    logic [15:0] br_addr [5];
    logic [7:0]  br_data [5];
    bw_addr = '{16'h07FF, 16'h0800, 16'h0FFF, 16'h1FFF, 16'h200F, 16'h2010, 16'hFFFF};
    bw_data = '{8'h11, 8'h22, 8'h23, 8'h33, 8'h44, 8'h55, 8'h66};
    br_addr = '{16'h07FF, 16'h1FFF, 16'h200F, 16'h0800, 16'h2010};
    br_data = '{8'h11, 8'h33, 8'h44, 8'h00, 8'h00};

    for (int i = 0; i < 2048; i++) tile_mem[i] = 8'h00;
    for (int i = 0; i < 4096; i++) attr_mem[i] = 8'h00;
    for (int i = 0; i < 16; i++) color_mem[i] = 8'h00;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    settle(1);
    chk("rst_ready", 32'(cpu_req_ready), 32'(1));
    chk("rst_rsp", 32'({cpu_rsp_valid, cpu_rsp_data}), 32'(0));
    chk("rst_unmapped", 32'(unmapped_count), 32'(0));
    chk("rst_stall", 32'(render_stall), 32'(0));
    chk("rst_we", 32'({tile_memory_write_enable, attribute_memory_write_enable,
                       color_memory_write_enable}), 32'(0));
    chk("rst_waddr", 32'({tile_memory_write_addr, attribute_memory_write_addr,
                          color_memory_write_addr}), 32'(0));
    chk("rst_wdata", 32'({tile_memory_write_data, attribute_memory_write_data,
                          color_memory_write_data}), 32'(0));
    checking = 1'b1;

    // One write into each memory, in order.
    obs.delete();
    cpu_write(16'h0100, 8'hAA, w);
    cpu_write(16'h1018, 8'hBE, w);
    cpu_write(16'h2002, 8'h0E, w);
    settle(4);
    chk("t1_count", 32'(obs.size()), 32'(3));
    chk("t1_w0", 32'(obs[0]), 32'({2'd0, 12'h100, 8'hAA}));
    chk("t1_w1", 32'(obs[1]), 32'({2'd1, 12'h018, 8'hBE}));
    chk("t1_w2", 32'(obs[2]), 32'({2'd2, 12'h002, 8'h0E}));

    // Five back-to-back writes never see ready drop.
    obs.delete();
    tot = 0;
    for (int i = 0; i < 5; i++) begin
      cpu_write(16'h0010 + 16'(i), 8'hC0 + 8'(i), w);
      tot += w;
    end
    settle(4);
    chk("t2_ready_waits", 32'(tot), 32'(0));
    chk("t2_count", 32'(obs.size()), 32'(5));
    cpu_read(16'h0013, w, acc, rsp);
    chk("t2_readback", 32'(cpu_rsp_data), 32'(8'hC3));

    // Read immediately behind a write is held until the write drains.
    cpu_write(16'h0005, 8'h5A, w);
    cpu_read(16'h0005, w, acc, rsp);
    chk("t3_read_held", 32'(w >= 1), 32'(1));
    chk("t3_data", 32'(cpu_rsp_data), 32'(8'h5A));
    chk("t3_latency", 32'(rsp - acc), 32'(2));

    // Renderer holds the tile port for 10 cycles.
    cpu_write(16'h0007, 8'h77, w);
    settle(3);
    fork
      begin
        render_tile_read_addr = 11'h123;
        render_tile_read_enable = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        render_tile_read_enable = 1'b0;
        fall = cyc;
      end
      cpu_read(16'h0007, w, acc, rsp);
    join
    chk("t4_after_fall", 32'(rsp - fall), 32'(2));
    chk("t4_data", 32'(cpu_rsp_data), 32'(8'h77));

    // Unmapped read and write.
    obs.delete();
    cpu_read(16'h3000, w, acc, rsp);
    chk("t5_latency", 32'(rsp - acc), 32'(1));
    chk("t5_data", 32'(cpu_rsp_data), 32'(0));
    cpu_write(16'h4000, 8'h11, w);
    settle(3);
    chk("t5_no_write", 32'(obs.size()), 32'(0));
    chk("t5_unmapped", 32'(unmapped_count), 32'(2));
    chk("t5_unmapped_model", 32'(unmapped_count), 32'(model_unmapped));

    // Starvation: renderer holds the attribute port.
    cpu_write(16'h1000, 8'h3C, w);
    settle(3);
    s0 = stall_count;
    fork
      begin
        render_attribute_read_addr = 12'h055;
        render_attribute_read_enable = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        render_attribute_read_enable = 1'b0;
        fall = cyc;
      end
      cpu_read(16'h1000, w, acc, rsp);
    join
`ifdef STARVE_GUARD_EN
    chk("t6_stall_pulses", 32'(stall_count - s0), 32'(1));
    chk("t6_stall_time", 32'(stall_cyc - acc), 32'(16));
    chk("t6_rsp_after_stall", 32'(rsp - stall_cyc), 32'(2));
`else
    chk("t6_stall_pulses", 32'(stall_count - s0), 32'(0));
    chk("t6_rsp_after_fall", 32'(rsp - fall), 32'(2));
`endif
    chk("t6_data", 32'(cpu_rsp_data), 32'(8'h3C));

    // Region boundaries.
    for (int i = 0; i < 7; i++) cpu_write(bw_addr[i], bw_data[i], w);
    for (int i = 0; i < 5; i++) begin
      cpu_read(br_addr[i], w, acc, rsp);
      chk("t7_boundary_data", 32'(cpu_rsp_data), 32'(br_data[i]));
    end
    settle(2);
    chk("t7_unmapped", 32'(unmapped_count), 32'(8));
    chk("t7_unmapped_model", 32'(unmapped_count), 32'(model_unmapped));

    // Counter saturation.
    for (int i = 0; i < 260; i++) cpu_write(16'h8000, 8'(i), w);
    settle(3);
    chk("t8_saturated", 32'(unmapped_count), 32'(8'hFF));
    chk("t8_saturated_model", 32'(unmapped_count), 32'(model_unmapped));

    // Reset with writes still queued.
    obs.delete();
    cpu_write(16'h0300, 8'h90, w);
    cpu_write(16'h0301, 8'h91, w);
    cpu_write(16'h0302, 8'h92, w);
    reset_n = 1'b0;
    exp_wr.delete();
    obs.delete();
    model_unmapped = 0;
    settle(2);
    chk("t9_in_reset_we", 32'({tile_memory_write_enable, attribute_memory_write_enable,
                               color_memory_write_enable}), 32'(0));
    reset_n = 1'b1;
    settle(4);
    chk("t9_no_writes", 32'(obs.size()), 32'(0));
    chk("t9_ready", 32'(cpu_req_ready), 32'(1));
    chk("t9_unmapped", 32'(unmapped_count), 32'(0));
    chk("t9_rsp_valid", 32'(cpu_rsp_valid), 32'(0));

    // Normal operation after reset.
    cpu_write(16'h0200, 8'h42, w);
    cpu_read(16'h0200, w, acc, rsp);
    chk("t10_data", 32'(cpu_rsp_data), 32'(8'h42));
    chk("t10_latency", 32'(rsp - acc), 32'(2));

    settle(4);
    chk("end_writes_drained", 32'(exp_wr.size()), 32'(0));
    chk("end_reads_drained", 32'(exp_rd.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vram_access_scheduler.md
Name: vram_access_scheduler

Overview:
- Sequences CPU-side accesses into the GPU's tile (2 KiB), attribute (4 KiB) and color (16 B) memories.
- Buffers CPU writes in a small FIFO and drains them to the memory write ports.
- Shares each memory's read port between the renderer (priority) and CPU read-back.
- Sits between the CPU bus front end (already in the clk domain) and the three memory instances.

Parameters:
- FIFO_DEPTH, 4, write FIFO entries; power of two, 2..16
- STARVE_LIMIT, 16, cycles a CPU read may wait before forcing a port steal (only used with STARVE_GUARD_EN)

Ports:
- clk in 1 system clock; all logic on rising edge
- reset_n in 1 asynchronous active-low reset
- cpu_req_valid in 1 request present
- cpu_req_rw in 1 1=read, 0=write
- cpu_req_addr in 16 unified VRAM address
- cpu_req_data in 8 write data
- cpu_req_ready out 1 request accepted when valid&&ready
- cpu_rsp_valid out 1 one-cycle pulse, read data valid
- cpu_rsp_data out 8 read data
- render_{tile,attribute,color}_read_enable in 1 each, renderer read requests
- render_{tile,attribute,color}_read_addr in 11/12/4 renderer read addresses
- render_stall out 1 renderer must hold its current request (STARVE_GUARD_EN only)
- {tile,attribute,color}_memory_read_enable out 1 each, to memories
- {tile,attribute,color}_memory_read_addr out 11/12/4
- {tile,attribute,color}_memory_read_data in 8 each, from memories; valid one cycle after enable
- {tile,attribute,color}_memory_write_enable out 1 each
- {tile,attribute,color}_memory_write_addr out 11/12/4
- {tile,attribute,color}_memory_write_data out 8 each
- unmapped_count out 8 saturating count of unmapped accesses

Behaviour:
- Address map:
  - 0x0000-0x07FF tile, addr[10:0]
  - 0x1000-0x1FFF attribute, addr[11:0]
  - 0x2000-0x200F color, addr[3:0]
  - everything else is unmapped.
- Reset (async assert, sync release):
  - FIFO empty, state IDLE.
  - All enables, cpu_rsp_valid, cpu_rsp_data, render_stall and unmapped_count are 0; write addr/data are 0.
  - Reset mid-operation discards queued writes and any pending read response.
- cpu_req_ready:
  - Write: state==IDLE && !fifo_full.
  - Read: state==IDLE && fifo_empty && no write issuing this cycle, which guarantees read-after-write ordering.
- Write path:
  - Accepted at edge N; the entry is popped and the decoded write_enable is registered high for the cycle after N.
  - Drains 1 write/cycle. Push and pop in the same cycle leave the count unchanged.
  - An unmapped write is popped with no enable asserted; unmapped_count increments.
- Read FSM:
  - IDLE: an accepted read latches addr and region; go to RD_WAIT, or RD_DATA if unmapped.
  - RD_WAIT: each cycle, if the target render_*_read_enable is low, assert cpu_grant (combinational) and go to RD_DATA.
  - RD_DATA: register the target read_data (0x00 if unmapped, and increment unmapped_count) into cpu_rsp_data; pulse cpu_rsp_valid; go to IDLE.
  - Minimum read latency, accept to rsp_valid: 2 cycles mapped, 1 cycle unmapped.
- Read port mux (combinational): mem_read_enable = render_en | cpu_grant; mem_read_addr = cpu_grant ? cpu_addr : render_addr. cpu_grant is never high while render_en is high, except for a steal.
- unmapped_count saturates at 0xFF.
- CPU write and read handshakes never stall the renderer.

Optional Feature:
- Macro: STARVE_GUARD_EN.
- Enabled:
  - A wait counter runs in RD_WAIT and clears on entry.
  - When it reaches STARVE_LIMIT, cpu_grant is forced for one cycle and render_stall goes high that cycle.
  - The renderer must re-issue its request; its read_data that cycle is invalid.
- Disabled: render_stall is tied 0; the CPU read waits indefinitely.

Decomposition:
- Package gpu_vram_pkg:
  - region base/mask constants;
  - TILE_AW=11, ATTR_AW=12, COLOR_AW=4;
  - region enum {REG_TILE, REG_ATTR, REG_COLOR, REG_NONE};
  - decode function;
  - FSM state enum {IDLE, RD_WAIT, RD_DATA}.
- Sub-module vram_write_fifo: a synchronous FIFO with {region, addr, data} entries, push/pop/full/empty, and async active-low reset.

Test Plan:
- Write 0x0100<-0xAA, then 0x1018<-0xBE, then 0x2002<-0x0E -> tile_we at addr 0x100 data 0xAA; attr_we at 0x018 data 0xBE; color_we at 0x2 data 0x0E; one cycle each, in order.
- Hold the drain off by issuing 5 back-to-back writes (FIFO_DEPTH=4) -> cpu_req_ready stays high (drain 1/cycle); all 5 land in order; no loss.
- Write 0x0005<-0x5A, then immediately read 0x0005 -> the read is not accepted until the FIFO is empty; rsp_data=0x5A.
- Hold render_tile_read_enable high for 10 cycles and read 0x0007 -> rsp_valid exactly 2 cycles after render_en falls; the renderer's addr is never overridden.
- Read 0x3000 and write 0x4000<-0x11 -> rsp 0x00 after 1 cycle; no write enable; unmapped_count=2.
- STARVE_GUARD_EN with render_attribute_read_enable held high and a read of 0x1000 -> after 16 cycles render_stall pulses 1 cycle and cpu_rsp_valid follows; without the macro, no response and render_stall=0.
- Additional check: assert reset_n low with 3 writes queued -> no write enables after reset; ready=1, unmapped_count=0.
